// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide controller.
package muldiv_pkg;

    // Operation codes carried on the op input
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    // Controller state encoding
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    // Signed variants have op[0] clear
    function automatic logic op_is_signed(input logic [1:0] op_v);
        return ~op_v[0];
    endfunction

    // Divide variants have op[1] set
    function automatic logic op_is_div(input logic [1:0] op_v);
        return op_v[1];
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation of a W-bit value.
module muldiv_signfix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_c_o
);

    // Negate when requested, pass through otherwise
    always_comb begin
        res_c_o = val_i;
        if (neg_i) begin
            res_c_o = ~val_i + W'(1);
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU controller with architectural HI/LO registers.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [W2-1:0]      acc_q, acc_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [W2-1:0]      prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;
    logic               res_neg;
    logic [WIDTH:0]     add_sum;
    logic [W2-1:0]      mul_next;
    logic [WIDTH:0]     div_sh, div_diff;
    logic [W2-1:0]      div_next;

    // Operand magnitudes at start: absolute value for signed ops, raw otherwise
    muldiv_signfix #(.W(WIDTH)) u_mag_a (
        .val_i   (a),
        .neg_i   (op_is_signed(op) & a[WIDTH-1]),
        .res_c_o (mag_a)
    );

    muldiv_signfix #(.W(WIDTH)) u_mag_b (
        .val_i   (b),
        .neg_i   (op_is_signed(op) & b[WIDTH-1]),
        .res_c_o (mag_b)
    );

    // Result sign correction used in FIX (truncating division semantics)
    assign res_neg = op_is_signed(op_q) & (sign_a_q ^ sign_b_q);

    muldiv_signfix #(.W(W2)) u_fix_prod (
        .val_i   (acc_q),
        .neg_i   (res_neg),
        .res_c_o (prod_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_quo (
        .val_i   (acc_q[WIDTH-1:0]),
        .neg_i   (res_neg),
        .res_c_o (quo_fix)
    );

    muldiv_signfix #(.W(WIDTH)) u_fix_rem (
        .val_i   (acc_q[W2-1:WIDTH]),
        .neg_i   (op_is_signed(op_q) & sign_a_q),
        .res_c_o (rem_fix)
    );

    // One shift-add step: conditional add into upper half, then shift right
    always_comb begin
        add_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : (WIDTH+1)'(0));
        mul_next = {add_sum, acc_q[WIDTH-1:1]};
    end

    // One restoring divide step on {remainder, quotient}
    always_comb begin
        div_sh   = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opb_q};
        div_next = {(div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                    acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
    end

    // Next-state, datapath and HI/LO update
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        dbz_d    = dbz_q;
        a_raw_d  = a_raw_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        if (hi_we) begin
            hi_d = wdata;
        end
        if (lo_we) begin
            lo_d = wdata;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = CALC;
                    cnt_d    = '0;
                    op_d     = op;
                    sign_a_d = a[WIDTH-1];
                    sign_b_d = b[WIDTH-1];
                    dbz_d    = op_is_div(op) && (b == '0);
                    a_raw_d  = a;
                    opb_d    = mag_b;
                    acc_d    = {WIDTH'(0), mag_a};
                end
            end
            CALC: begin
                acc_d = op_is_div(op_q) ? div_next : mul_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (op_is_div(op_q)) begin
                    if (dbz_q) begin
                        lo_d = '1;
                        hi_d = a_raw_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[W2-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            dbz_q    <= 1'b0;
            a_raw_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            dbz_q    <= dbz_d;
            a_raw_q  <= a_raw_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl at WIDTH = 32.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    localparam int unsigned WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_cmp;
    int n_err;
    int cyc;
    int pulses;

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an operation now, let the next edge sample it, then drop start
    task automatic issue(input logic [1:0] o, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Edges after the sampling edge until done is seen (bounded)
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done !== 1'b1) begin
            check("timeout", 64'(n), 64'd0);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        op    = OP_MULT;
        a     = '0;
        b     = '0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        wdata = '0;

        // Reset state
        step(2);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1);

        // MULTU max*max with latency: done after edge E0+33 (34 cycles incl. start cycle)
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("multu_lat", 64'(cyc), 64'd33);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        check("done_busy0", 64'(busy), 64'd0);
        step(1);
        check("done_1cyc", 64'(done), 64'd0);

        // MULT -3 * 5
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFF1);
        step(1);

        // DIV -7/2 then DIVU 7/2 issued in the done cycle
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        issue(OP_DIVU, 32'd7, 32'd2);
        check("b2b_busy", 64'(busy), 64'd1);
        wait_done(cyc);
        check("b2b_lat", 64'(cyc), 64'd33);
        check("divu_lo", 64'(lo), 64'd3);
        check("divu_hi", 64'(hi), 64'd1);
        step(1);

        // Divide by zero, signed and unsigned
        issue(OP_DIV, 32'h1234_5678, 32'd0);
        wait_done(cyc);
        check("dbz_lat", 64'(cyc), 64'd33);
        check("dbz_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dbz_hi", 64'(hi), 64'h1234_5678);
        step(1);
        issue(OP_DIVU, 32'h1234_5678, 32'd0);
        wait_done(cyc);
        check("dbzu_lo", 64'(lo), 64'hFFFF_FFFF);
        check("dbzu_hi", 64'(hi), 64'h1234_5678);
        step(1);

        // Most-negative / -1
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc);
        check("ovf_lo", 64'(lo), 64'h8000_0000);
        check("ovf_hi", 64'(hi), 64'd0);
        step(1);

        // start pulsed mid-CALC is ignored
        issue(OP_MULTU, 32'd6, 32'd7);
        step(10);
        issue(OP_DIV, 32'd100, 32'd3);
        wait_done(cyc);
        check("ign_lat", 64'(cyc), 64'd22);
        check("ign_lo", 64'(lo), 64'd42);
        check("ign_hi", 64'(hi), 64'd0);
        step(1);

        // MTHI in IDLE
        hi_we = 1'b1;
        wdata = 32'h55;
        step(1);
        hi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h55);

        // MTLO during CALC, then overwritten by the result
        issue(OP_MULTU, 32'd3, 32'd4);
        step(5);
        lo_we = 1'b1;
        wdata = 32'hAA;
        step(1);
        lo_we = 1'b0;
        check("mtlo_calc", 64'(lo), 64'hAA);
        wait_done(cyc);
        check("mtlo_res_lo", 64'(lo), 64'd12);
        check("mtlo_res_hi", 64'(hi), 64'd0);
        step(1);

        // MTHI coinciding with the FIX write: result wins
        issue(OP_MULTU, 32'd2, 32'd3);
        step(32);
        hi_we = 1'b1;
        wdata = 32'hDEAD;
        step(1);
        hi_we = 1'b0;
        check("fixwin_done", 64'(done), 64'd1);
        check("fixwin_hi", 64'(hi), 64'd0);
        check("fixwin_lo", 64'(lo), 64'd6);
        step(1);

        // Reset mid-CALC aborts and clears HI/LO (load nonzero first)
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done(cyc);
        step(1);
        issue(OP_MULTU, 32'd9, 32'd9);
        step(5);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("arst_nodone", 64'(pulses), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
